sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 22, meaning the SDRAM word address width.
REQ-002 SHALL have parameter DATA_W, default 16, meaning the data width.
REQ-003 SHALL have parameter TAG_DEPTH, default 4, meaning the maximum number of outstanding reads (power of 2).
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports m0_addr (input, ADDR_W), m0_wdata (input, DATA_W), m0_read (input, 1) and m0_write (input, 1), forming requester 0 (audio playrec).
REQ-007 SHALL have ports m0_waitrq (output, 1), m0_rdata (output, DATA_W) and m0_valid (output, 1), forming the requester 0 response.
REQ-008 SHALL have ports m1_addr, m1_wdata, m1_read, m1_write, m1_waitrq, m1_rdata and m1_valid, identical to the m0_* ports, forming requester 1 (display buffer).
REQ-009 SHALL have ports ram_addr (output, ADDR_W), ram_wdata (output, DATA_W), ram_read (output, 1) and ram_write (output, 1), driving the SDRAM controller.
REQ-010 SHALL have ports ram_rdata (input, DATA_W), ram_valid (input, 1) and ram_waitrq (input, 1), returned by the SDRAM controller.
REQ-011 SHALL have port err_orphan, output, 1, a sticky flag meaning ram_valid arrived with no outstanding read.

Function
REQ-012 SHALL use a two-state FSM, IDLE/GRANT, with registers gnt_id (1 bit) and last_id (1 bit).
REQ-013 SHALL, in IDLE with a request (mX_read|mX_write) from one master, grant that master, load gnt_id and go to GRANT next cycle.
REQ-014 SHALL, in IDLE with both masters requesting, grant !last_id (round-robin).
REQ-015 SHALL, in IDLE, drive ram_read=0 and ram_write=0 and hold both mX_waitrq=1.
REQ-016 SHALL, in GRANT, pass ram_addr, ram_wdata, ram_read and ram_write combinationally from master gnt_id; the non-granted master sees waitrq=1.
REQ-017 SHALL, if the granted master asserts both read and write, forward write only and force ram_read=0.
REQ-018 SHALL block a granted read while tag count == TAG_DEPTH: ram_read=0 and m_waitrq=1.
REQ-019 SHALL set granted m_waitrq = ram_waitrq whenever the command is not blocked.
REQ-020 SHALL treat the command as accepted when (ram_read|ram_write) & !ram_waitrq; on acceptance, last_id<=gnt_id and the FSM goes to IDLE.
REQ-021 SHALL return to IDLE without updating last_id if the granted master drops its request in GRANT before acceptance.
REQ-022 SHALL meet a minimum spacing of 2 cycles between accepted commands; arbitration latency is 1 cycle from request to ram command.
REQ-023 SHALL use a tag FIFO of TAG_DEPTH entries that pushes gnt_id on accepted reads and pops on ram_valid; simultaneous push and pop leaves the count unchanged.
REQ-024 SHALL, on ram_valid with a non-empty FIFO, register ram_rdata into m<head>_rdata and pulse m<head>_valid for exactly 1 cycle on the next edge (1-cycle latency); the other master's rdata holds its value.
REQ-025 SHALL, on ram_valid with an empty FIFO, discard the data, set err_orphan=1 (sticky until reset) and leave the count at 0.
REQ-026 SHALL keep the FIFO pointers wrapping modulo TAG_DEPTH and the count within 0..TAG_DEPTH.

Reset
REQ-027 SHALL, on reset asserted, immediately force: FSM=IDLE, last_id=1 (so master 0 wins the first tie), gnt_id=0, FIFO empty, err_orphan=0, m0_valid=m1_valid=0, m0_rdata=m1_rdata=0.
REQ-028 SHALL, while in reset, drive ram_read=ram_write=0 and m0_waitrq=m1_waitrq=1.
REQ-029 SHALL discard reads outstanding at reset; later ram_valid pulses for them set err_orphan.

Verification
REQ-030 SHALL cover: both masters write after reset (m0 addr 0x000010, m1 addr 0x200000), ram_waitrq=0 -> m0 accepted first, then m1, 2 cycles apart.
REQ-031 SHALL cover: both masters read continuously, ram_valid 3 cycles after each accept -> grants alternate 0,1,0,1 and each rdata returns only to its issuer.
REQ-032 SHALL cover: m0 issues 5 reads with ram_valid withheld -> 4 accepted, 5th held with m0_waitrq=1 until the first ram_valid.
REQ-033 SHALL cover: ram_waitrq=1 for 6 cycles during an m1 write -> ram_addr and ram_wdata stable, grant held, m0 request waits.
REQ-034 SHALL cover: ram_valid pulse with an empty FIFO -> err_orphan=1, no mX_valid; reset clears err_orphan to 0.
REQ-035 SHALL cover: reset asserted with 2 reads outstanding -> outputs at reset values the same cycle; 2 subsequent ram_valid -> err_orphan=1, no mX_valid.

Source files
------------

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-master round-robin arbiter in front of an SDRAM controller.
//
// Requester 0 (audio playrec) and requester 1 (display buffer) share one SDRAM
// command port. One command is granted at a time. Read responses are routed
// back to their issuer through an in-order tag FIFO.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   m0_* / m1_*                 requester command (addr, wdata, read, write) and
//                               response (waitrq, rdata, valid)
//   ram_addr/wdata/read/write   command to the SDRAM controller
//   ram_rdata/valid/waitrq      response and backpressure from the controller
//   err_orphan                  sticky: ram_valid arrived with no read outstanding
module sdram_arbiter #(
    parameter int unsigned ADDR_W    = 22,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned TAG_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_read,
    input  logic              m0_write,
    output logic              m0_waitrq,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_valid,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_read,
    input  logic              m1_write,
    output logic              m1_waitrq,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_valid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_read,
    output logic              ram_write,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_valid,
    input  logic              ram_waitrq,
    output logic              err_orphan
);

    localparam int unsigned PtrW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(TAG_DEPTH + 1);
    localparam logic [CntW-1:0] Full    = CntW'(TAG_DEPTH);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(TAG_DEPTH - 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e          state_q;
    logic            gnt_id_q;
    logic            last_id_q;

    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            tags_q [TAG_DEPTH];

    logic            req0;
    logic            req1;
    logic            g_read;
    logic            g_write;
    logic            in_grant;
    logic            cmd_read;
    logic            blocked;
    logic            gnt_waitrq;
    logic            accept;
    logic            push;
    logic            pop;
    logic            orphan;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    assign req0    = m0_read | m0_write;
    assign req1    = m1_read | m1_write;
    assign g_read  = gnt_id_q ? m1_read  : m0_read;
    assign g_write = gnt_id_q ? m1_write : m0_write;

    assign ram_addr  = gnt_id_q ? m1_addr  : m0_addr;
    assign ram_wdata = gnt_id_q ? m1_wdata : m0_wdata;

    always_comb begin
        in_grant   = (state_q == StGrant);
        // Read+write together forwards only the write.
        cmd_read   = in_grant & g_read & ~g_write;
        // Reads stall while every tag slot is in use; writes never stall here.
        blocked    = cmd_read & (count_q == Full);
        ram_read   = cmd_read & ~blocked;
        ram_write  = in_grant & g_write;
        gnt_waitrq = blocked | ram_waitrq;
        m0_waitrq  = (in_grant && !gnt_id_q) ? gnt_waitrq : 1'b1;
        m1_waitrq  = (in_grant &&  gnt_id_q) ? gnt_waitrq : 1'b1;
        accept     = (ram_read | ram_write) & ~ram_waitrq;
        push       = accept & ram_read;
        pop        = ram_valid & (count_q != '0);
        orphan     = ram_valid & (count_q == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            gnt_id_q  <= 1'b0;
            last_id_q <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req0 | req1) begin
                        gnt_id_q <= (req0 & req1) ? ~last_id_q : req1;
                        state_q  <= StGrant;
                    end
                end
                StGrant: begin
                    if (accept) begin
                        last_id_q <= gnt_id_q;
                        state_q   <= StIdle;
                    end else if (!(g_read | g_write)) begin
                        // Requester withdrew: release without moving round-robin.
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Tag storage needs no reset: only slots between the pointers are read.
    always_ff @(posedge clk) begin
        if (push) begin
            tags_q[wr_ptr_q] <= gnt_id_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_orphan <= 1'b0;
            m0_valid   <= 1'b0;
            m1_valid   <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            m0_valid <= 1'b0;
            m1_valid <= 1'b0;
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
                if (tags_q[rd_ptr_q]) begin
                    m1_rdata <= ram_rdata;
                    m1_valid <= 1'b1;
                end else begin
                    m0_rdata <= ram_rdata;
                    m0_valid <= 1'b1;
                end
            end
            if (orphan) begin
                err_orphan <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: a cycle table for arbitration and
// backpressure, then scoreboarded read traffic, tag-FIFO limits and orphans.
module tb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [21:0] m0_addr, m1_addr, ram_addr;
    logic [15:0] m0_wdata, m1_wdata, ram_wdata;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic        m0_waitrq, m1_waitrq, m0_valid, m1_valid;
    logic [15:0] m0_rdata, m1_rdata, ram_rdata;
    logic        ram_read, ram_write, ram_valid, ram_waitrq, err_orphan;

    sdram_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_read(m0_read), .m0_write(m0_write),
        .m0_waitrq(m0_waitrq), .m0_rdata(m0_rdata), .m0_valid(m0_valid),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_read(m1_read), .m1_write(m1_write),
        .m1_waitrq(m1_waitrq), .m1_rdata(m1_rdata), .m1_valid(m1_valid),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_read(ram_read),
        .ram_write(ram_write), .ram_rdata(ram_rdata), .ram_valid(ram_valid),
        .ram_waitrq(ram_waitrq), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [21:0] addr;
        logic [15:0] data;
    } cmd_t;

    typedef struct {
        logic       m0r, m0w, m1r, m1w, rwq;
        logic [3:0] exp;  // {ram_read, ram_write, m0_waitrq, m1_waitrq}
        int         src;  // expected ram_addr source, -1 when no command
    } vec_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          auto_m = 0;
    bit          ram_hold = 0;
    bit          inj_valid = 0;
    cmd_t        m0_cmds[$], m1_cmds[$];
    logic [15:0] exp0[$], exp1[$];
    logic [15:0] hold0 = '0, hold1 = '0;
    logic [21:0] pend_addr[$];
    int          pend_cnt[$];
    logic [21:0] acc_log[$];
    int          acc_cyc[$];
    vec_t        vecs [21];

    function automatic logic [15:0] rd_fn(input logic [21:0] a);
        return a[15:0] ^ 16'h5A00 ^ {10'd0, a[21:16]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue_read(input int m, input logic [21:0] a);
        cmd_t c;
        c.wr = 1'b0;
        c.addr = a;
        c.data = '0;
        if (m == 0) begin
            m0_cmds.push_back(c);
            exp0.push_back(rd_fn(a));
        end else begin
            m1_cmds.push_back(c);
            exp1.push_back(rd_fn(a));
        end
    endtask

    // End-of-cycle observation: SDRAM model capture, master handshakes, responses.
    task automatic sample_end();
        logic [15:0] e;
        if (ram_read && !ram_waitrq) begin
            pend_addr.push_back(ram_addr);
            pend_cnt.push_back(3);
        end
        if ((ram_read || ram_write) && !ram_waitrq) begin
            acc_log.push_back(ram_addr);
            acc_cyc.push_back(cyc);
        end
        if (auto_m) begin
            if (m0_cmds.size() > 0 && !m0_waitrq) void'(m0_cmds.pop_front());
            if (m1_cmds.size() > 0 && !m1_waitrq) void'(m1_cmds.pop_front());
        end
        if (m0_valid) begin
            if (exp0.size() == 0) begin
                total++; bad++;
                $display("FAIL m0_valid unexpected: got 1 expected 0");
            end else begin
                e = exp0.pop_front();
                check("m0_rdata", 32'(m0_rdata), 32'(e));
                hold0 = e;
                check("m1_rdata hold", 32'(m1_rdata), 32'(hold1));
            end
        end
        if (m1_valid) begin
            if (exp1.size() == 0) begin
                total++; bad++;
                $display("FAIL m1_valid unexpected: got 1 expected 0");
            end else begin
                e = exp1.pop_front();
                check("m1_rdata", 32'(m1_rdata), 32'(e));
                hold1 = e;
                check("m0_rdata hold", 32'(m0_rdata), 32'(hold0));
            end
        end
        cyc++;
    endtask

    // Start-of-cycle drive: SDRAM read returns and auto-master commands.
    task automatic drive_start();
        for (int i = 0; i < pend_cnt.size(); i++) pend_cnt[i] = pend_cnt[i] - 1;
        if (inj_valid) begin
            ram_valid = 1'b1;
            ram_rdata = 16'hDEAD;
            inj_valid = 0;
        end else if (!ram_hold && pend_cnt.size() > 0 && pend_cnt[0] <= 0) begin
            ram_valid = 1'b1;
            ram_rdata = rd_fn(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_cnt.pop_front());
        end else begin
            ram_valid = 1'b0;
        end
        if (auto_m) begin
            if (m0_cmds.size() > 0) begin
                m0_read = !m0_cmds[0].wr; m0_write = m0_cmds[0].wr;
                m0_addr = m0_cmds[0].addr; m0_wdata = m0_cmds[0].data;
            end else begin
                m0_read = 0; m0_write = 0;
            end
            if (m1_cmds.size() > 0) begin
                m1_read = !m1_cmds[0].wr; m1_write = m1_cmds[0].wr;
                m1_addr = m1_cmds[0].addr; m1_wdata = m1_cmds[0].data;
            end else begin
                m1_read = 0; m1_write = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample_end();
        @(posedge clk);
        #1;
        drive_start();
    endtask

    function automatic int busy();
        return m0_cmds.size() + m1_cmds.size() + exp0.size() + exp1.size() + pend_cnt.size();
    endfunction

    task automatic drain(input int limit, input string name);
        int n = 0;
        while (busy() != 0 && n < limit) begin
            tick();
            n++;
        end
        check({name, " drained"}, 32'(busy()), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("reset ctl {rr,rw,w0,w1,v0,v1,err}",
              32'({ram_read, ram_write, m0_waitrq, m1_waitrq, m0_valid, m1_valid, err_orphan}),
              32'(7'b0011000));
        check("reset m0_rdata", 32'(m0_rdata), 32'd0);
        check("reset m1_rdata", 32'(m1_rdata), 32'd0);
        m0_cmds.delete(); m1_cmds.delete();
        exp0.delete(); exp1.delete();
        hold0 = '0; hold1 = '0;
        acc_log.delete(); acc_cyc.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        m0_read = 0; m1_read = 1; m0_write = 1; m1_write = 0;
        ram_rdata = '0; ram_valid = 0; ram_waitrq = 0;

        vecs[0]  = '{0, 1, 0, 1, 0, 4'b0011, -1};
        vecs[1]  = '{0, 1, 0, 1, 0, 4'b0101,  0};
        vecs[2]  = '{0, 1, 0, 1, 0, 4'b0011, -1};
        vecs[3]  = '{0, 1, 0, 1, 0, 4'b0110,  1};
        vecs[4]  = '{1, 1, 0, 0, 0, 4'b0011, -1};
        vecs[5]  = '{1, 1, 0, 0, 0, 4'b0101,  0};
        vecs[6]  = '{0, 0, 0, 1, 1, 4'b0011, -1};
        for (int i = 7; i <= 12; i++) vecs[i] = '{0, 1, 0, 1, 1, 4'b0111, 1};
        vecs[13] = '{0, 1, 0, 1, 0, 4'b0110,  1};
        vecs[14] = '{0, 1, 0, 0, 0, 4'b0011, -1};
        vecs[15] = '{0, 1, 0, 0, 0, 4'b0101,  0};
        vecs[16] = '{0, 0, 1, 0, 0, 4'b0011, -1};
        vecs[17] = '{0, 0, 0, 0, 0, 4'b0010, -1};
        vecs[18] = '{0, 1, 0, 1, 0, 4'b0011, -1};
        vecs[19] = '{0, 1, 0, 1, 0, 4'b0110,  1};
        vecs[20] = '{0, 0, 0, 0, 0, 4'b0011, -1};

        @(posedge clk);
        #1;
        do_reset();

        // Arbitration, read+write priority, backpressure, withdrawn request.
        m0_addr = 22'h000010; m0_wdata = 16'h1111;
        m1_addr = 22'h200000; m1_wdata = 16'h2222;
        for (int i = 0; i < 21; i++) begin
            m0_read = vecs[i].m0r; m0_write = vecs[i].m0w;
            m1_read = vecs[i].m1r; m1_write = vecs[i].m1w;
            ram_waitrq = vecs[i].rwq;
            #1;
            check($sformatf("vec%0d ctl", i),
                  32'({ram_read, ram_write, m0_waitrq, m1_waitrq}), 32'(vecs[i].exp));
            if (vecs[i].src == 0) begin
                check($sformatf("vec%0d addr", i), 32'(ram_addr), 32'h000010);
                check($sformatf("vec%0d wdata", i), 32'(ram_wdata), 32'h1111);
            end else if (vecs[i].src == 1) begin
                check($sformatf("vec%0d addr", i), 32'(ram_addr), 32'h200000);
                check($sformatf("vec%0d wdata", i), 32'(ram_wdata), 32'h2222);
            end
            tick();
        end
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0; ram_waitrq = 0;

        // Both masters read continuously: alternate grants, 2-cycle spacing.
        do_reset();
        auto_m = 1;
        for (int i = 0; i < 4; i++) begin
            issue_read(0, 22'h000100 + 22'(i));
            issue_read(1, 22'h200300 + 22'(i));
        end
        drain(100, "alternating reads");
        check("alt accept count", 32'(acc_log.size()), 32'd8);
        for (int i = 0; i < acc_log.size() && i < 8; i++) begin
            check($sformatf("alt order %0d", i), 32'(acc_log[i]),
                  (i % 2 == 0) ? 32'h000100 + 32'(i / 2) : 32'h200300 + 32'(i / 2));
            if (i > 0) check($sformatf("alt spacing %0d", i),
                             32'(acc_cyc[i] - acc_cyc[i-1]), 32'd2);
        end
        check("alt err_orphan", 32'(err_orphan), 32'd0);

        // Five reads with responses withheld: the fifth waits for a tag.
        do_reset();
        ram_hold = 1;
        for (int i = 0; i < 5; i++) issue_read(0, 22'h000200 + 22'(i));
        for (int i = 0; i < 16; i++) tick();
        #1;
        check("full accept count", 32'(acc_log.size()), 32'd4);
        check("full pending cmds", 32'(m0_cmds.size()), 32'd1);
        check("full blocked {rr,w0}", 32'({ram_read, m0_waitrq}), 32'(2'b01));
        ram_hold = 0;
        tick();
        #1;
        check("full first valid {rr,w0}", 32'({ram_read, m0_waitrq}), 32'(2'b01));
        tick();
        #1;
        check("full released {rr,w0}", 32'({ram_read, m0_waitrq}), 32'(2'b10));
        drain(60, "full fifo");

        // Response with nothing outstanding.
        do_reset();
        auto_m = 0;
        inj_valid = 1;
        tick();
        tick();
        #1;
        check("orphan set {err,v0,v1}", 32'({err_orphan, m0_valid, m1_valid}), 32'(3'b100));
        tick();
        check("orphan sticky", 32'(err_orphan), 32'd1);
        do_reset();
        check("orphan cleared", 32'(err_orphan), 32'd0);

        // Reset with two reads outstanding; their late responses are orphans.
        auto_m = 1;
        ram_hold = 1;
        issue_read(0, 22'h000400);
        issue_read(1, 22'h200500);
        issue_read(0, 22'h000401);
        n = 0;
        while (acc_log.size() < 2 && n < 20) begin
            tick();
            n++;
        end
        check("outstanding accepts", 32'(acc_log.size()), 32'd2);
        tick();
        #1;
        check("third read presented", 32'(ram_read), 32'd1);
        do_reset();
        ram_hold = 0;
        drain(20, "late responses");
        tick();
        tick();
        check("late orphan", 32'(err_orphan), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
